// File: rtl/ps2_keyboard_rx.sv
// PS/2 set-2 keyboard receiver: frames bits, decodes scan codes to ASCII, writes the char FIFO.
// Optional build macro PS2_CAPSLOCK_EN adds a Caps Lock toggle on make code 0x58.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       fifo_full,
  output logic       fifo_wr_en,
  output logic [7:0] fifo_wr_data,
  output logic       frame_error,
  output logic [7:0] drop_count
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_s;
  logic          dat_s;
  logic          filt;
  logic [FW-1:0] filt_cnt;
  logic          strobe;

  state_t        state;
  state_t        state_n;
  logic [3:0]    bit_cnt;
  logic [9:0]    sh;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          frame_ok;

  logic          byte_vld;
  logic [7:0]    byte_q;
  logic          brk;
  logic          ext;
  logic          shift;
  logic          case_flag;
  logic [9:0]    lk;
  logic          emit_q;
  logic [7:0]    emit_char;
  logic [7:0]    last_data;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
    end
  end

  // Level flips only after FILTER_LEN differing samples in a row; strobe marks a 1->0 flip.
  always_ff @(posedge clock) begin
    if (reset) begin
      filt     <= 1'b1;
      filt_cnt <= '0;
      strobe   <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (clk_s == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt     <= clk_s;
        filt_cnt <= '0;
        strobe   <= filt;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign timeout  = (state == RECV) && !strobe &&
                    (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign frame_ok = (^sh[8:0]) && sh[9];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (strobe && !dat_s) state_n = RECV;
      RECV: begin
        if (strobe && bit_cnt == 4'd9) state_n = CHECK;
        else if (timeout)              state_n = IDLE;
      end
      CHECK: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt     <= '0;
      sh          <= '0;
      tcnt        <= '0;
      byte_vld    <= 1'b0;
      byte_q      <= '0;
      frame_error <= 1'b0;
    end else begin
      if (state == IDLE && strobe && !dat_s) begin
        bit_cnt <= '0;
        tcnt    <= '0;
      end else if (state == RECV) begin
        if (strobe) begin
          sh      <= {dat_s, sh[9:1]};
          bit_cnt <= bit_cnt + 1'b1;
          tcnt    <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
      byte_vld    <= (state == CHECK) && frame_ok;
      byte_q      <= sh[7:0];
      frame_error <= timeout || ((state == CHECK) && !frame_ok);
    end
  end

  // Returns {mapped, is_letter, ascii}.
  function automatic logic [9:0] lookup(input logic [7:0] c);
    logic [9:0] r;
    r = '0;
    case (c)
      8'h1C: r = {2'b11, 8'h61};
      8'h32: r = {2'b11, 8'h62};
      8'h21: r = {2'b11, 8'h63};
      8'h23: r = {2'b11, 8'h64};
      8'h24: r = {2'b11, 8'h65};
      8'h2B: r = {2'b11, 8'h66};
      8'h34: r = {2'b11, 8'h67};
      8'h33: r = {2'b11, 8'h68};
      8'h43: r = {2'b11, 8'h69};
      8'h3B: r = {2'b11, 8'h6A};
      8'h42: r = {2'b11, 8'h6B};
      8'h4B: r = {2'b11, 8'h6C};
      8'h3A: r = {2'b11, 8'h6D};
      8'h31: r = {2'b11, 8'h6E};
      8'h44: r = {2'b11, 8'h6F};
      8'h4D: r = {2'b11, 8'h70};
      8'h15: r = {2'b11, 8'h71};
      8'h2D: r = {2'b11, 8'h72};
      8'h1B: r = {2'b11, 8'h73};
      8'h2C: r = {2'b11, 8'h74};
      8'h3C: r = {2'b11, 8'h75};
      8'h2A: r = {2'b11, 8'h76};
      8'h1D: r = {2'b11, 8'h77};
      8'h22: r = {2'b11, 8'h78};
      8'h35: r = {2'b11, 8'h79};
      8'h1A: r = {2'b11, 8'h7A};
      8'h45: r = {2'b10, 8'h30};
      8'h16: r = {2'b10, 8'h31};
      8'h1E: r = {2'b10, 8'h32};
      8'h26: r = {2'b10, 8'h33};
      8'h25: r = {2'b10, 8'h34};
      8'h2E: r = {2'b10, 8'h35};
      8'h36: r = {2'b10, 8'h36};
      8'h3D: r = {2'b10, 8'h37};
      8'h3E: r = {2'b10, 8'h38};
      8'h46: r = {2'b10, 8'h39};
      8'h29: r = {2'b10, 8'h20};
      8'h5A: r = {2'b10, 8'h0D};
      8'h66: r = {2'b10, 8'h08};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign lk = lookup(byte_q);

`ifdef PS2_CAPSLOCK_EN
  logic caps_lock;
  assign case_flag = shift ^ caps_lock;

  always_ff @(posedge clock) begin
    if (reset)
      caps_lock <= 1'b0;
    else if (byte_vld && !brk && !ext && byte_q == 8'h58)
      caps_lock <= ~caps_lock;
  end
`else
  assign case_flag = shift;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      brk       <= 1'b0;
      ext       <= 1'b0;
      shift     <= 1'b0;
      emit_q    <= 1'b0;
      emit_char <= '0;
    end else begin
      emit_q <= 1'b0;
      if (byte_vld) begin
        if (byte_q == 8'hF0) begin
          brk <= 1'b1;
        end else if (byte_q == 8'hE0) begin
          ext <= 1'b1;
        end else if (brk) begin
          if (!ext && (byte_q == 8'h12 || byte_q == 8'h59))
            shift <= 1'b0;
          brk <= 1'b0;
          ext <= 1'b0;
        end else begin
          ext <= 1'b0;
          if (!ext && (byte_q == 8'h12 || byte_q == 8'h59))
            shift <= 1'b1;
          if (ext) begin
            if (byte_q == 8'h5A) begin
              emit_q    <= 1'b1;
              emit_char <= 8'h0D;
            end
          end else if (lk[9]) begin
            emit_q    <= 1'b1;
            emit_char <= (lk[8] && case_flag) ? lk[7:0] - 8'h20 : lk[7:0];
          end
        end
      end
    end
  end

  assign fifo_wr_en   = emit_q && !fifo_full;
  assign fifo_wr_data = fifo_wr_en ? emit_char : last_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_data  <= '0;
      drop_count <= '0;
    end else begin
      if (fifo_wr_en)
        last_data <= emit_char;
      if (emit_q && fifo_full && drop_count != 8'hFF)
        drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: drives PS/2 frames, records FIFO writes and error pulses.
module tb_ps2_keyboard_rx;

  localparam int FILT = 4;
  localparam int TMO  = 2000;
  localparam int HALF = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       fifo_full = 1'b0;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic       frame_error;
  logic [7:0] drop_count;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  logic [7:0] wr_q[$];

  ps2_keyboard_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .frame_error(frame_error),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset) begin
      if (fifo_wr_en) wr_q.push_back(fifo_wr_data);
      if (frame_error) err_cnt++;
    end
  end

  function automatic logic [7:0] q_at(input int i);
    if (i < wr_q.size()) return wr_q[i];
    return 8'hxx;
  endfunction

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clock);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clock);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ bad_par);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(posedge clock);
  endtask

  task automatic clear_log();
    wr_q.delete();
    err_cnt = 0;
  endtask

  task automatic check_writes(input string name, input int n,
                              input logic [7:0] a, input logic [7:0] b);
    checks++;
    if (wr_q.size() !== n) begin
      failures++;
      $display("FAIL %s count: got %0d want %0d", name, wr_q.size(), n);
    end
    if (n > 0) begin
      checks++;
      if (q_at(0) !== a) begin
        failures++;
        $display("FAIL %s byte0: got %h want %h", name, q_at(0), a);
      end
    end
    if (n > 1) begin
      checks++;
      if (q_at(1) !== b) begin
        failures++;
        $display("FAIL %s byte1: got %h want %h", name, q_at(1), b);
      end
    end
  endtask

  task automatic test_reset();
    repeat (5) @(posedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({fifo_wr_en, frame_error} !== 2'b00) begin
      failures++;
      $display("FAIL reset_pulses: got %b want 00", {fifo_wr_en, frame_error});
    end
    checks++;
    if (fifo_wr_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: got %h want 00", fifo_wr_data);
    end
    checks++;
    if (drop_count !== 8'h00) begin
      failures++;
      $display("FAIL reset_drop: got %h want 00", drop_count);
    end
  endtask

  task automatic test_make_break();
    clear_log();
    send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check_writes("make_break", 1, 8'h61, 8'h00);
    checks++;
    if (fifo_wr_data !== 8'h61) begin
      failures++;
      $display("FAIL hold_data: got %h want 61", fifo_wr_data);
    end
  endtask

  task automatic test_shift();
    clear_log();
    send_frame(8'h12, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h12, 1'b0);
    send_frame(8'h1C, 1'b0);
    check_writes("shift", 2, 8'h41, 8'h61);
    clear_log();
    send_frame(8'h59, 1'b0);
    send_frame(8'h16, 1'b0);
    send_frame(8'h1A, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h59, 1'b0);
    check_writes("shift_digit_z", 2, 8'h31, 8'h5A);
  endtask

  task automatic test_parity_ext();
    clear_log();
    send_frame(8'h1C, 1'b1);
    checks++;
    if (err_cnt !== 1) begin
      failures++;
      $display("FAIL parity_err: got %0d want 1", err_cnt);
    end
    check_writes("parity_nowrite", 0, 8'h00, 8'h00);
    clear_log();
    send_frame(8'h5A, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h5A, 1'b0);
    check_writes("enter", 2, 8'h0D, 8'h0D);
    clear_log();
    send_frame(8'hE0, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0);
    check_writes("ext_ignored", 1, 8'h61, 8'h00);
  endtask

  task automatic test_timeout();
    clear_log();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TMO + 100) @(posedge clock);
    checks++;
    if (err_cnt !== 1) begin
      failures++;
      $display("FAIL timeout_err: got %0d want 1", err_cnt);
    end
    clear_log();
    send_frame(8'h66, 1'b0);
    check_writes("after_timeout", 1, 8'h08, 8'h00);
  endtask

  task automatic test_drop();
    clear_log();
    fifo_full = 1'b1;
    send_frame(8'h29, 1'b0);
    check_writes("drop_nowrite", 0, 8'h00, 8'h00);
    checks++;
    if (drop_count !== 8'd1) begin
      failures++;
      $display("FAIL drop_one: got %0d want 1", drop_count);
    end
    for (int i = 0; i < 299; i++) send_frame(8'h29, 1'b0);
    checks++;
    if (drop_count !== 8'd255) begin
      failures++;
      $display("FAIL drop_sat: got %0d want 255", drop_count);
    end
    fifo_full = 1'b0;
    send_frame(8'h29, 1'b0);
    check_writes("after_full", 1, 8'h20, 8'h00);
  endtask

  task automatic test_reset_midframe();
    clear_log();
    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
    reset = 1'b1;
    repeat (4) @(posedge clock);
    reset = 1'b0;
    repeat (4) @(posedge clock);
    checks++;
    if (drop_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_drop_clr: got %0d want 0", drop_count);
    end
    send_frame(8'h29, 1'b0);
    check_writes("reset_mid", 1, 8'h20, 8'h00);
    checks++;
    if (err_cnt !== 0) begin
      failures++;
      $display("FAIL reset_mid_err: got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_caps();
    logic [7:0] exp;
`ifdef PS2_CAPSLOCK_EN
    exp = 8'h41;
`else
    exp = 8'h61;
`endif
    clear_log();
    send_frame(8'h58, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h58, 1'b0);
    send_frame(8'h1C, 1'b0);
    check_writes("caps", 1, exp, 8'h00);
  endtask

  task automatic test_back_to_back();
    clear_log();
    send_frame(8'h24, 1'b0);
    send_frame(8'h24, 1'b0);
    send_frame(8'h24, 1'b0);
    check_writes("typematic", 3, 8'h65, 8'h65);
    checks++;
    if (q_at(2) !== 8'h65) begin
      failures++;
      $display("FAIL typematic_byte2: got %h want 65", q_at(2));
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_shift();
    test_parity_ext();
    test_timeout();
    test_drop();
    test_reset_midframe();
    test_caps();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
